// File: rtl/memory_wrapper.sv
// Single-port synchronous RAM with active-low chip enable and a registered read port.
// Storage is never reset; only the read register clears on reset.
module memory_wrapper #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cen,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  mem_we;
  logic                  rd_en;

  always_comb begin
    mem_we  = ~reset & ~cen & wr_en;
    rd_en   = ~cen & ~wr_en;
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem_q[addr];
    end
  end

  // Array write port: reset suppresses writes but never clears contents
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_memory_wrapper.sv
// Directed self-checking bench for memory_wrapper: reset, fill/readback, idle hold,
// write isolation from rdata and reset in the middle of a write/read sequence.
module tb_memory_wrapper;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cen;
  logic          wr_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [DW-1:0] exp_mem [DEPTH];

  memory_wrapper #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .cen   (cen),
    .wr_en (wr_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic c, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    reset = r;
    cen   = c;
    wr_en = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 6'd3, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_cnt++;
      if (rdata !== 32'h0) $display("FAIL reset_hold[%0d] rdata=%h required=%h", i, rdata, 32'h0);
      else pass_cnt++;
    end
    drive(1'b0, 1'b1, 1'b0, 6'd0, 32'h0);
    tick();
    check_cnt++;
    if (rdata !== 32'h0) $display("FAIL reset_release rdata=%h required=%h", rdata, 32'h0);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 6'd3, 32'h0);
    tick();
    check_cnt++;
    if (rdata === 32'hDEADBEEF) $display("FAIL reset_no_write rdata=%h required=not deadbeef", rdata);
    else pass_cnt++;
  endtask

  task automatic test_fill_readback();
    drive(1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 1'b0, 1'b1, AW'(a), DW'(a));
      exp_mem[a] = DW'(a);
      tick();
      check_cnt++;
      if (rdata !== 32'h0) $display("FAIL fill_write_hold[%0d] rdata=%h required=%h", a, rdata, 32'h0);
      else pass_cnt++;
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 1'b0, 1'b0, AW'(a), 32'hFFFF0000);
      tick();
      check_cnt++;
      if (rdata !== DW'(a)) $display("FAIL fill_read[%0d] rdata=%h required=%h", a, rdata, DW'(a));
      else pass_cnt++;
    end
  endtask

  task automatic test_write_then_read();
    drive(1'b0, 1'b0, 1'b1, 6'd10, 32'hA5A5A5A5);
    exp_mem[10] = 32'hA5A5A5A5;
    tick();
    check_cnt++;
    if (rdata !== 32'h3F) $display("FAIL wtr_no_writethrough rdata=%h required=%h", rdata, 32'h3F);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 6'd10, 32'h0);
    tick();
    check_cnt++;
    if (rdata !== 32'hA5A5A5A5) $display("FAIL wtr_read rdata=%h required=%h", rdata, 32'hA5A5A5A5);
    else pass_cnt++;
  endtask

  task automatic test_idle_hold();
    drive(1'b0, 1'b0, 1'b0, 6'd5, 32'h0);
    tick();
    check_cnt++;
    if (rdata !== 32'h5) $display("FAIL idle_read5 rdata=%h required=%h", rdata, 32'h5);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, i[0], AW'(i * 7), 32'hC0DE0000 | DW'(i));
      tick();
      check_cnt++;
      if (rdata !== 32'h5) $display("FAIL idle_hold[%0d] rdata=%h required=%h", i, rdata, 32'h5);
      else pass_cnt++;
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 1'b0, 1'b0, AW'(a), 32'h0);
      tick();
      check_cnt++;
      if (rdata !== exp_mem[a]) $display("FAIL idle_readback[%0d] rdata=%h required=%h", a, rdata, exp_mem[a]);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_no_disturb();
    drive(1'b0, 1'b0, 1'b0, 6'd7, 32'h0);
    tick();
    check_cnt++;
    if (rdata !== 32'h7) $display("FAIL wnd_read7 rdata=%h required=%h", rdata, 32'h7);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b1, 6'd7, 32'h12345678);
    exp_mem[7] = 32'h12345678;
    tick();
    check_cnt++;
    if (rdata !== 32'h7) $display("FAIL wnd_after_write rdata=%h required=%h", rdata, 32'h7);
    else pass_cnt++;
    drive(1'b0, 1'b1, 1'b0, 6'd7, 32'h0);
    tick();
    check_cnt++;
    if (rdata !== 32'h7) $display("FAIL wnd_idle rdata=%h required=%h", rdata, 32'h7);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 6'd7, 32'h0);
    tick();
    check_cnt++;
    if (rdata !== 32'h12345678) $display("FAIL wnd_reread rdata=%h required=%h", rdata, 32'h12345678);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    drive(1'b0, 1'b0, 1'b1, 6'd0, 32'hFFFFFFFF);
    exp_mem[0] = 32'hFFFFFFFF;
    tick();
    // Write sampled with reset must be dropped
    drive(1'b1, 1'b0, 1'b1, 6'd0, 32'h11111111);
    tick();
    check_cnt++;
    if (rdata !== 32'h0) $display("FAIL rst_mid_write rdata=%h required=%h", rdata, 32'h0);
    else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    tick();
    check_cnt++;
    if (rdata !== 32'h0) $display("FAIL rst_mid_read rdata=%h required=%h", rdata, 32'h0);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    tick();
    check_cnt++;
    if (rdata !== 32'hFFFFFFFF) $display("FAIL rst_mid_first_read rdata=%h required=%h", rdata, 32'hFFFFFFFF);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 6'd10, 32'h0);
    tick();
    check_cnt++;
    if (rdata !== exp_mem[10]) $display("FAIL rst_mid_b2b_read rdata=%h required=%h", rdata, exp_mem[10]);
    else pass_cnt++;
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    test_reset();
    test_fill_readback();
    test_write_then_read();
    test_idle_hold();
    test_write_no_disturb();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
